// File: rtl/random_range_sampler_pkg.sv
// Shared types and defaults for the random range sampler.
// The fallback default only exists when RAND_MOD_FALLBACK_EN is defined.
package random_range_sampler_pkg;

  localparam int DEFAULT_WIDTH = 32;
`ifdef RAND_MOD_FALLBACK_EN
  localparam int DEFAULT_MAX_TRIES = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/random_range_sampler_if.sv
// Request/result handshake plus the generator enable/value pair.
// The master side is the game logic and the scripted generator; the sampler is the slave.
interface random_range_sampler_if
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             req;
  logic [WIDTH-1:0] min_value;
  logic [WIDTH-1:0] max_value;
  logic             rng_enable;
  logic [WIDTH-1:0] rng_value;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] value;

  modport master (
    output req, min_value, max_value, rng_value,
    input  rng_enable, busy, valid, value
  );

  modport slave (
    input  req, min_value, max_value, rng_value,
    output rng_enable, busy, valid, value
  );
endinterface

// File: rtl/random_range_sampler_mask_gen.sv
// Combinational span -> mask: smallest 2^k-1 that covers span (0 for span 0).
// Built as a leading-one smear so it can be shared by other samplers.
module rand_mask_gen
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] span_i,
  output logic [WIDTH-1:0] mask_o
);

  logic [WIDTH-1:0] smear;

  // Each shift doubles the run of ones below the leading one.
  always_comb begin
    smear = span_i;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      smear = smear | (smear >> s);
    end
  end

  assign mask_o = smear;

endmodule

// File: rtl/random_range_sampler.sv
// Uniform sampler in [lo, hi] by mask-and-reject over an external LFSR generator.
// Define RAND_MOD_FALLBACK_EN to bound retries with a fold-back after MAX_TRIES draws.
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef RAND_MOD_FALLBACK_EN
  , parameter int MAX_TRIES = DEFAULT_MAX_TRIES
`endif
) (
  input logic                   clk,
  input logic                   reset,
  random_range_sampler_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             rng_en_q, rng_en_d;
  logic [WIDTH-1:0] span;
  logic [WIDTH-1:0] mask;

`ifdef RAND_MOD_FALLBACK_EN
  localparam int TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  logic [TRIES_W-1:0] tries_q, tries_d;
`endif

  assign span = hi_q - lo_q;

  rand_mask_gen #(.WIDTH(WIDTH)) u_mask_gen (
    .span_i (span),
    .mask_o (mask)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cand_d  = cand_q;
    value_d = value_q;
`ifdef RAND_MOD_FALLBACK_EN
    tries_d = tries_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.min_value > bus.max_value) begin
            lo_d = bus.max_value;
            hi_d = bus.min_value;
          end else begin
            lo_d = bus.min_value;
            hi_d = bus.max_value;
          end
          state_d = S_PULSE;
        end
      end
      S_PULSE: state_d = S_WAIT;
      S_WAIT: begin
        cand_d  = bus.rng_value & mask;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cand_q <= span) begin
          value_d = lo_q + cand_q;
          state_d = S_DONE;
`ifdef RAND_MOD_FALLBACK_EN
        end else if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
          // cand <= 2*span+1, so folding down by span+1 stays within [lo, hi].
          value_d = lo_q + (cand_q - span - WIDTH'(1));
          state_d = S_DONE;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
          state_d = S_PULSE;
        end
`else
        end else begin
          state_d = S_PULSE;
        end
`endif
      end
      S_DONE: begin
`ifdef RAND_MOD_FALLBACK_EN
        tries_d = '0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rng_en_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cand_q   <= '0;
      value_q  <= '0;
      rng_en_q <= 1'b0;
`ifdef RAND_MOD_FALLBACK_EN
      tries_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cand_q   <= cand_d;
      value_q  <= value_d;
      rng_en_q <= rng_en_d;
`ifdef RAND_MOD_FALLBACK_EN
      tries_q  <= tries_d;
`endif
    end
  end

  always_comb begin
    bus.busy       = (state_q == S_PULSE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    bus.valid      = (state_q == S_DONE);
    bus.rng_enable = rng_en_q;
    bus.value      = value_q;
  end

endmodule
